// File: rtl/stream_demux_n.sv
// Registered 1-to-N packet demultiplexer with valid/ready flow control.
// The destination is locked on a packet's first beat; out-of-range packets are dropped and counted.
module stream_demux_n #(
  parameter int N_CH  = 4,
  parameter int DW    = 8,
  parameter int SEL_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DW-1:0]     s_data,
  input  logic              s_last,
  input  logic [SEL_W-1:0]  s_sel,
  output logic [N_CH-1:0]   m_valid,
  input  logic [N_CH-1:0]   m_ready,
  output logic [N_CH*DW-1:0] m_data,
  output logic [N_CH-1:0]   m_last,
  output logic              busy,
  output logic [SEL_W-1:0]  cur_ch,
  output logic [7:0]        drop_cnt
);

  typedef enum logic [1:0] {IDLE, PASS, DROP} state_t;

  state_t           state;
  logic [SEL_W-1:0] tgt;
  logic             in_range;
  logic             tgt_free;
  logic             pass_beat;
  logic             accept;
  logic [N_CH-1:0]  load;

  // Once a packet is open the locked channel is the target, otherwise s_sel is.
  assign tgt      = (state == PASS) ? cur_ch : s_sel;
  assign in_range = (32'(s_sel) < N_CH);

  always_comb begin
    tgt_free = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      if (tgt == SEL_W'(k)) begin
        tgt_free = !m_valid[k] || m_ready[k];
      end
    end
  end

  always_comb begin
    s_ready = 1'b1;
    case (state)
      IDLE:    s_ready = in_range ? tgt_free : 1'b1;
      PASS:    s_ready = tgt_free;
      DROP:    s_ready = 1'b1;
      default: s_ready = 1'b1;
    endcase
  end

  assign pass_beat = (state == PASS) || ((state == IDLE) && in_range);
  assign accept    = s_valid && s_ready;

  always_comb begin
    load = '0;
    for (int k = 0; k < N_CH; k++) begin
      load[k] = accept && pass_beat && (tgt == SEL_W'(k));
    end
  end

  // A load wins over a drain in the same cycle so the channel never bubbles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      m_valid  <= '0;
      m_data   <= '0;
      m_last   <= '0;
      busy     <= 1'b0;
      cur_ch   <= '0;
      drop_cnt <= '0;
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        if (load[k]) begin
          m_valid[k]           <= 1'b1;
          m_data[k*DW +: DW]   <= s_data;
          m_last[k]            <= s_last;
        end else if (m_ready[k]) begin
          m_valid[k] <= 1'b0;
        end
      end

      if (accept) begin
        case (state)
          IDLE: begin
            if (in_range) begin
              if (!s_last) begin
                state  <= PASS;
                cur_ch <= s_sel;
                busy   <= 1'b1;
              end
            end else begin
              if (drop_cnt != 8'hFF) begin
                drop_cnt <= drop_cnt + 8'd1;
              end
              if (!s_last) begin
                state <= DROP;
                busy  <= 1'b1;
              end
            end
          end
          PASS: begin
            if (s_last) begin
              state  <= IDLE;
              cur_ch <= '0;
              busy   <= 1'b0;
            end
          end
          DROP: begin
            if (s_last) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
          default: begin
            state  <= IDLE;
            cur_ch <= '0;
            busy   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_stream_demux_n.sv
// Directed bench for stream_demux_n: a 4-channel instance for routing and
// a 3-channel instance for out-of-range drop counting.
module tb_stream_demux_n;

  logic        clk;
  logic        rst_n;

  logic        s_valid, s_ready, s_last, busy;
  logic [7:0]  s_data, drop_cnt;
  logic [1:0]  s_sel, cur_ch;
  logic [3:0]  m_valid, m_ready, m_last;
  logic [31:0] m_data;

  logic        d3_s_valid, d3_s_ready, d3_s_last, d3_busy;
  logic [7:0]  d3_s_data, d3_drop_cnt;
  logic [1:0]  d3_s_sel, d3_cur_ch;
  logic [2:0]  d3_m_valid, d3_m_ready, d3_m_last;
  logic [23:0] d3_m_data;

  int checks   = 0;
  int failures = 0;

  stream_demux_n #(.N_CH(4), .DW(8), .SEL_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last), .s_sel(s_sel),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy), .cur_ch(cur_ch), .drop_cnt(drop_cnt)
  );

  stream_demux_n #(.N_CH(3), .DW(8), .SEL_W(2)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .s_valid(d3_s_valid), .s_ready(d3_s_ready), .s_data(d3_s_data), .s_last(d3_s_last), .s_sel(d3_s_sel),
    .m_valid(d3_m_valid), .m_ready(d3_m_ready), .m_data(d3_m_data), .m_last(d3_m_last),
    .busy(d3_busy), .cur_ch(d3_cur_ch), .drop_cnt(d3_drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Inputs change 1ns after the rising edge; outputs are sampled there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic l, input logic [1:0] sel);
    s_valid = v;
    s_data  = d;
    s_last  = l;
    s_sel   = sel;
    #1;
  endtask

  task automatic applyDropStimulus(input logic v, input logic [7:0] d, input logic l, input logic [1:0] sel);
    d3_s_valid = v;
    d3_s_data  = d;
    d3_s_last  = l;
    d3_s_sel   = sel;
    #1;
  endtask

  task automatic sendDropPacket();
    for (int b = 0; b < 4; b++) begin
      applyDropStimulus(1'b1, 8'(8'h40 + b), (b == 3), 2'd3);
      step();
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    m_ready    = 4'hF;
    d3_m_ready = 3'h7;
    applyStimulus(1'b1, 8'h11, 1'b1, 2'd1);
    applyDropStimulus(1'b0, 8'h00, 1'b0, 2'd0);

    // Reset held for two edges with a beat pending
    step();
    step();
    checkOutput("rst_m_valid", 32'(m_valid), 32'h0);
    checkOutput("rst_m_data", m_data, 32'h0);
    checkOutput("rst_m_last", 32'(m_last), 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'h0);
    checkOutput("rst_cur_ch", 32'(cur_ch), 32'h0);
    checkOutput("rst_drop_cnt", 32'(drop_cnt), 32'h0);
    checkOutput("rst_d3_m_valid", 32'(d3_m_valid), 32'h0);

    rst_n = 1'b1;
    step();
    checkOutput("post_rst_m_valid", 32'(m_valid), 32'h2);
    checkOutput("post_rst_data_ch1", 32'(m_data[15:8]), 32'h11);
    checkOutput("post_rst_busy", 32'(busy), 32'h0);
    applyStimulus(1'b0, 8'h00, 1'b0, 2'd0);
    step();
    checkOutput("drain_m_valid", 32'(m_valid), 32'h0);

    // Select lock: s_sel wanders after the first beat
    applyStimulus(1'b1, 8'hA1, 1'b0, 2'd2);
    checkOutput("lock_ready_a1", 32'(s_ready), 32'h1);
    step();
    checkOutput("lock_valid_a1", 32'(m_valid), 32'h4);
    checkOutput("lock_data_a1", 32'(m_data[23:16]), 32'hA1);
    checkOutput("lock_busy_a1", 32'(busy), 32'h1);
    checkOutput("lock_cur_ch_a1", 32'(cur_ch), 32'h2);
    applyStimulus(1'b1, 8'hA2, 1'b0, 2'd0);
    step();
    checkOutput("lock_valid_a2", 32'(m_valid), 32'h4);
    checkOutput("lock_data_a2", 32'(m_data[23:16]), 32'hA2);
    checkOutput("lock_cur_ch_a2", 32'(cur_ch), 32'h2);
    applyStimulus(1'b1, 8'hA3, 1'b1, 2'd0);
    step();
    checkOutput("lock_valid_a3", 32'(m_valid), 32'h4);
    checkOutput("lock_data_a3", 32'(m_data[23:16]), 32'hA3);
    checkOutput("lock_last_a3", 32'(m_last[2]), 32'h1);
    checkOutput("lock_busy_end", 32'(busy), 32'h0);
    checkOutput("lock_cur_ch_end", 32'(cur_ch), 32'h0);
    applyStimulus(1'b0, 8'h00, 1'b0, 2'd0);
    step();

    // Backpressure on channel 1 while channel 3 holds its own beat
    m_ready = 4'h0;
    applyStimulus(1'b1, 8'hC0, 1'b1, 2'd3);
    step();
    checkOutput("bp_ch3_loaded", 32'(m_valid), 32'h8);
    applyStimulus(1'b1, 8'hB1, 1'b0, 2'd1);
    checkOutput("bp_ready_b1", 32'(s_ready), 32'h1);
    step();
    checkOutput("bp_valid_b1", 32'(m_valid), 32'hA);
    checkOutput("bp_cur_ch", 32'(cur_ch), 32'h1);
    m_ready = 4'h8;
    applyStimulus(1'b1, 8'hB2, 1'b1, 2'd1);
    checkOutput("bp_stall", 32'(s_ready), 32'h0);
    step();
    checkOutput("bp_ch3_drained", 32'(m_valid), 32'h2);
    checkOutput("bp_hold_b1", 32'(m_data[15:8]), 32'hB1);
    m_ready = 4'h0;
    #1;
    checkOutput("bp_still_stall", 32'(s_ready), 32'h0);
    m_ready = 4'h2;
    #1;
    checkOutput("bp_release", 32'(s_ready), 32'h1);
    step();
    checkOutput("bp_valid_b2", 32'(m_valid), 32'h2);
    checkOutput("bp_data_b2", 32'(m_data[15:8]), 32'hB2);
    checkOutput("bp_last_b2", 32'(m_last[1]), 32'h1);
    checkOutput("bp_busy_end", 32'(busy), 32'h0);
    m_ready = 4'hF;
    applyStimulus(1'b0, 8'h00, 1'b0, 2'd0);
    step();

    // Back-to-back single-beat packets to every channel
    for (int c = 0; c < 4; c++) begin
      applyStimulus(1'b1, 8'(8'hD0 + c), 1'b1, 2'(c));
      checkOutput($sformatf("b2b_ready_%0d", c), 32'(s_ready), 32'h1);
      step();
      checkOutput($sformatf("b2b_valid_%0d", c), 32'(m_valid), 32'(1 << c));
      checkOutput($sformatf("b2b_data_%0d", c), 32'(m_data[c*8 +: 8]), 32'(8'hD0 + c));
      checkOutput($sformatf("b2b_busy_%0d", c), 32'(busy), 32'h0);
    end
    applyStimulus(1'b0, 8'h00, 1'b0, 2'd0);
    step();

    // Reset in the middle of a packet to channel 0
    m_ready = 4'h0;
    applyStimulus(1'b1, 8'hE1, 1'b0, 2'd0);
    step();
    applyStimulus(1'b1, 8'hE2, 1'b0, 2'd0);
    step();
    checkOutput("mid_busy", 32'(busy), 32'h1);
    rst_n = 1'b0;
    applyStimulus(1'b1, 8'hE3, 1'b0, 2'd0);
    step();
    checkOutput("mid_rst_valid", 32'(m_valid), 32'h0);
    checkOutput("mid_rst_busy", 32'(busy), 32'h0);
    checkOutput("mid_rst_data", m_data, 32'h0);
    rst_n   = 1'b1;
    m_ready = 4'hF;
    applyStimulus(1'b1, 8'hF1, 1'b1, 2'd1);
    step();
    checkOutput("mid_new_valid", 32'(m_valid), 32'h2);
    checkOutput("mid_new_data", 32'(m_data[15:8]), 32'hF1);
    applyStimulus(1'b0, 8'h00, 1'b0, 2'd0);

    // Out-of-range packets on the 3-channel instance
    for (int b = 0; b < 4; b++) begin
      applyDropStimulus(1'b1, 8'(8'h30 + b), (b == 3), 2'd3);
      checkOutput($sformatf("drop_ready_%0d", b), 32'(d3_s_ready), 32'h1);
      step();
      checkOutput($sformatf("drop_no_valid_%0d", b), 32'(d3_m_valid), 32'h0);
      checkOutput($sformatf("drop_busy_%0d", b), 32'(d3_busy), (b == 3) ? 32'h0 : 32'h1);
    end
    checkOutput("drop_cnt_one", 32'(d3_drop_cnt), 32'h1);
    for (int p = 1; p < 255; p++) sendDropPacket();
    checkOutput("drop_cnt_255", 32'(d3_drop_cnt), 32'hFF);
    sendDropPacket();
    checkOutput("drop_cnt_sat", 32'(d3_drop_cnt), 32'hFF);
    applyDropStimulus(1'b1, 8'h77, 1'b1, 2'd2);
    step();
    checkOutput("d3_pass_valid", 32'(d3_m_valid), 32'h4);
    checkOutput("d3_pass_data", 32'(d3_m_data[23:16]), 32'h77);
    checkOutput("d3_cnt_kept", 32'(d3_drop_cnt), 32'hFF);
    applyDropStimulus(1'b0, 8'h00, 1'b0, 2'd0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stream_demux_n.md
# stream_demux_n

Registered, parameterised 1-to-N packet demultiplexer with valid/ready flow control. It is the successor to the team's combinational 1x4 demux. It locks the select on the first beat of a packet and holds it until that packet's last beat. Each channel has a one-deep output register with independent backpressure, and packets addressed to a non-existent channel are dropped and counted. It sits between a single upstream stream source and N downstream consumers.

## Interface
- N_CH, 4: number of output channels, 2..16.
- DW, 8: data width per beat.
- SEL_W, 2: select width; must satisfy 2**SEL_W >= N_CH.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- s_valid  in  1  input beat valid.
- s_ready  out  1  input beat accepted when s_valid && s_ready at the clk edge.
- s_data  in  DW  input beat data.
- s_last  in  1  marks the final beat of a packet.
- s_sel  in  SEL_W  destination channel; sampled only on the first beat of a packet.
- m_valid  out  N_CH  per-channel output valid.
- m_ready  in  N_CH  per-channel output ready.
- m_data  out  N_CH*DW  channel k occupies bits [k*DW +: DW].
- m_last  out  N_CH  per-channel last flag.
- busy  out  1  high while a packet is open (state PASS or DROP).
- cur_ch  out  SEL_W  channel locked for the open packet; 0 when idle.
- drop_cnt  out  8  number of dropped packets; saturates at 255.

## Operation
- **FSM states:** IDLE, PASS, DROP.
- **IDLE, tgt = s_sel:**
  - In range (s_sel < N_CH): s_ready = !m_valid[tgt] || m_ready[tgt]. On an accepted beat, load the beat into channel tgt. Go to PASS with cur_ch = tgt if !s_last; stay in IDLE if s_last (single-beat packet).
  - Out of range (s_sel >= N_CH): s_ready = 1 and the beat is discarded. drop_cnt increments on this first beat. Go to DROP if !s_last; stay in IDLE if s_last.
- **PASS:**
  - s_sel is ignored.
  - s_ready = !m_valid[cur_ch] || m_ready[cur_ch].
  - Each accepted beat loads into channel cur_ch.
  - An accepted s_last returns to IDLE, and cur_ch returns to 0.
- **DROP:**
  - s_ready = 1 and every beat is discarded.
  - An accepted s_last returns to IDLE.
  - drop_cnt does not change.
- **Channel register k:**
  - On load: m_valid[k]=1, m_data[k]=s_data, m_last[k]=s_last.
  - When m_valid[k] && m_ready[k] and no load in the same cycle: m_valid[k]=0. m_data and m_last hold their values.
  - Drain and load in the same cycle: the new beat replaces the old one and m_valid stays 1. There is no bubble.
  - Channels other than the target drain independently and are never stalled by input traffic.
- m_ready of a non-target channel never affects s_ready.
- drop_cnt saturates: at 255 it holds 255.

## Timing
- **Reset** (rst_n=0 at an edge): state=IDLE, m_valid=0, m_data=0, m_last=0, cur_ch=0, busy=0, drop_cnt=0.
  - Reset takes priority over any transfer in the same cycle.
  - Reset mid-packet abandons the packet and discards any buffered beats.
  - After release, the next beat is treated as a first beat.
- s_ready is combinational from state, s_sel, m_valid and m_ready. It has no combinational dependency on s_valid.
- Latency: a beat accepted at edge t is visible on m_data/m_valid after edge t. Minimum path is one cycle.
- Throughput: one beat per cycle while m_ready[target] stays high.
- busy and cur_ch are registered outputs. They change on the edge that accepts the first beat or the last beat of a packet.
- A single-beat packet leaves busy at 0 throughout.
- If s_valid is held high, the first beat of the next packet can be accepted on the cycle immediately after the last beat of the previous packet.

## Test plan
- **Reset values:** hold rst_n=0 for 2 cycles with s_valid=1, s_sel=1 -> all outputs 0 and s_ready is don't-care. Release reset -> first beat lands on channel 1.
- **Select lock:** 3-beat packet with s_sel=2 and data A1,A2,A3. s_sel changes to 0 on beats 2 and 3 and all m_ready=1 -> all beats appear on channel 2 only, with m_last[2]=1 on A3. busy is 1 during the packet and cur_ch=2.
- **Backpressure:** m_ready[1]=0 with a 2-beat packet to channel 1 -> first beat is buffered and s_ready=0 until m_ready[1]=1. Channel 3 drains concurrently without any effect on s_ready.
- **Out-of-range drop:** N_CH=3, SEL_W=2, 4-beat packet with s_sel=3 -> s_ready=1 on all beats, no m_valid asserted, drop_cnt=1. Repeat 256 times -> drop_cnt saturates at 255.
- **Back-to-back single-beat packets:** s_sel=0,1,2,3 on consecutive cycles with all s_last=1 and m_ready all 1 -> each channel gets one beat in consecutive cycles and busy stays 0.
- **Mid-packet reset:** assert reset after beat 2 of a 4-beat packet to channel 0 -> m_valid=0 after the reset edge. A new packet with s_sel=1 is then routed to channel 1.
